// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor, DIGIT bits per cycle, LSB digit first
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic             carry_in_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cy_q;
    logic [CW-1:0]    step_q;
    logic [CW-1:0]    step_d;
    logic             carry_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] dsum_ext;

    // One digit slice: ripple through DIGIT full adders seeded by the carry flop.
    // chain[DIGIT-1] is the carry into the slice MSB, which on the last step is
    // the carry into the operand MSB needed for signed overflow.
    always_comb begin
        chain    = '0;
        dsum     = '0;
        dsum_ext = '0;
        chain[0] = cy_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]      = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i + 1] = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
        end
        dsum_ext[DIGIT-1:0] = dsum;
        sum_d  = (sum_q >> DIGIT) | (dsum_ext << (WIDTH - DIGIT));
        step_d = step_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            step_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        cy_q    <= sub_i ? 1'b1 : carry_in_i;
                        step_q  <= '0;
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    a_q    <= a_q >> DIGIT;
                    b_q    <= b_q >> DIGIT;
                    sum_q  <= sum_d;
                    cy_q   <= chain[DIGIT];
                    step_q <= step_d;
                    if (step_q == LAST_STEP) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        carry_q <= chain[DIGIT];
                        ovf_q   <= chain[DIGIT] ^ chain[DIGIT-1];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sum_o      = sum_q;
    assign carry_o    = carry_q;
    assign overflow_o = ovf_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - bench for serial_adder across five WIDTH/DIGIT configurations
module tb_serial_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  sum0, sum1, sum2, sum3;
    logic [15:0] sum4;
    logic [4:0]  carry, ovf, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .sub_i(sub), .carry_in_i(cin),
        .a_i(a[7:0]), .b_i(b[7:0]), .sum_o(sum0), .carry_o(carry[0]),
        .overflow_o(ovf[0]), .busy_o(busy[0]), .done_o(done[0]));
    serial_adder #(.WIDTH(8), .DIGIT(2)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .sub_i(sub), .carry_in_i(cin),
        .a_i(a[7:0]), .b_i(b[7:0]), .sum_o(sum1), .carry_o(carry[1]),
        .overflow_o(ovf[1]), .busy_o(busy[1]), .done_o(done[1]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .sub_i(sub), .carry_in_i(cin),
        .a_i(a[7:0]), .b_i(b[7:0]), .sum_o(sum2), .carry_o(carry[2]),
        .overflow_o(ovf[2]), .busy_o(busy[2]), .done_o(done[2]));
    serial_adder #(.WIDTH(8), .DIGIT(8)) u3 (
        .clk_i(clk), .rst_i(rst), .start_i(start[3]), .sub_i(sub), .carry_in_i(cin),
        .a_i(a[7:0]), .b_i(b[7:0]), .sum_o(sum3), .carry_o(carry[3]),
        .overflow_o(ovf[3]), .busy_o(busy[3]), .done_o(done[3]));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start[4]), .sub_i(sub), .carry_in_i(cin),
        .a_i(a), .b_i(b), .sum_o(sum4), .carry_o(carry[4]),
        .overflow_o(ovf[4]), .busy_o(busy[4]), .done_o(done[4]));

    function automatic int width_of(input int cfg);
        return (cfg == 4) ? 16 : 8;
    endfunction

    function automatic int digit_of(input int cfg);
        case (cfg)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] sum_of(input int cfg);
        case (cfg)
            0:       return {8'h00, sum0};
            1:       return {8'h00, sum1};
            2:       return {8'h00, sum2};
            3:       return {8'h00, sum3};
            default: return sum4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input int w, input bit s, input bit ci,
                         input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] es, output logic ec, output logic eo);
        longint m, ua, ub, sa, sb, r, sr;
        m  = longint'(1) << w;
        ua = longint'(av) & (m - 1);
        ub = longint'(bv) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            r  = ua - ub;
            sr = sa - sb;
            ec = (ua >= ub);
        end else begin
            r  = ua + ub + longint'(ci);
            sr = sa + sb + longint'(ci);
            ec = (r >= m);
        end
        es = 16'(r & (m - 1));
        eo = (sr >= m / 2) || (sr < -(m / 2));
    endtask

    task automatic run_op(input int cfg, input bit s, input bit ci,
                          input logic [15:0] av, input logic [15:0] bv,
                          input int restart_at, input string tag);
        logic [15:0] es;
        logic        ec, eo;
        int          edges;
        model(width_of(cfg), s, ci, av, bv, es, ec, eo);
        @(negedge clk);
        a = av; b = bv; sub = s; cin = ci; start[cfg] = 1'b1;
        @(posedge clk);
        #1;
        start[cfg] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        chk({tag, "_busy"}, 32'(busy[cfg]), 32'd1);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            cin = 1'($urandom);
            if (done[cfg]) break;
            start[cfg] = (edges == restart_at);
        end
        start[cfg] = 1'b0;
        chk({tag, "_latency"}, 32'(edges), 32'(width_of(cfg) / digit_of(cfg)));
        chk({tag, "_sum"}, 32'(sum_of(cfg)), 32'(es));
        chk({tag, "_carry"}, 32'(carry[cfg]), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf[cfg]), 32'(eo));
    endtask

    initial begin
        int pulses[$];
        rst = 1'b1; start = '0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("rst_sum", 32'(sum_of(c)), 32'd0);
            chk("rst_carry", 32'(carry[c]), 32'd0);
            chk("rst_ovf", 32'(ovf[c]), 32'd0);
            chk("rst_busy", 32'(busy[c]), 32'd0);
            chk("rst_done", 32'(done[c]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 1'b0, 1'b0, 16'h005A, 16'h003C, 0, "add_ovf");
        chk("add_ovf_const_sum", 32'(sum0), 32'h96);
        run_op(0, 1'b0, 1'b0, 16'h00FF, 16'h0001, 0, "wrap");
        run_op(0, 1'b0, 1'b1, 16'h0000, 16'h0000, 0, "cin");
        run_op(0, 1'b1, 1'b0, 16'h0010, 16'h0020, 0, "sub_borrow");
        run_op(0, 1'b1, 1'b1, 16'h0080, 16'h0001, 0, "sub_ovf");

        // Done lasts one cycle; results hold through IDLE.
        @(posedge clk);
        #1;
        chk("done_width", 32'(done[0]), 32'd0);
        chk("idle_busy", 32'(busy[0]), 32'd0);
        chk("hold_sum", 32'(sum0), 32'h7F);
        chk("hold_carry", 32'(carry[0]), 32'd1);
        chk("hold_ovf", 32'(ovf[0]), 32'd1);

        run_op(0, 1'b0, 1'b0, 16'h0012, 16'h0034, 2, "restart_ign");

        // Start held high: back-to-back results every N+1 cycles.
        @(negedge clk);
        a = 16'h0021; b = 16'h0013; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                pulses.push_back(e);
                chk("b2b_sum", 32'(sum0), 32'h34);
            end
            if (e == 26) start[0] = 1'b0;
        end
        chk("b2b_count", 32'(pulses.size()), 32'd3);
        for (int i = 0; i < pulses.size(); i++)
            chk("b2b_pos", 32'(pulses[i]), 32'(8 + 9 * i));
        @(posedge clk);
        #1;
        chk("b2b_done_drop", 32'(done[0]), 32'd0);
        chk("b2b_idle", 32'(busy[0]), 32'd0);

        // Reset at the 4th RUN edge after a result with Carry=Overflow=1.
        run_op(0, 1'b1, 1'b0, 16'h0080, 16'h0001, 0, "pre_rst");
        @(negedge clk);
        a = 16'h00C3; b = 16'h0055; sub = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sum", 32'(sum0), 32'd0);
        chk("mid_rst_carry", 32'(carry[0]), 32'd0);
        chk("mid_rst_ovf", 32'(ovf[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(busy[0]), 32'd0);
        run_op(0, 1'b0, 1'b0, 16'h0001, 16'h0002, 0, "post_rst");

        for (int c = 0; c < 5; c++)
            for (int i = 0; i < 1000; i++)
                run_op(c, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 0, "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor built from a repeated full-adder digit slice with a registered carry between slices. It adds or subtracts two WIDTH-bit operands over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle, LSB digit first. It replaces wide combinational ripple adders in datapaths where area matters more than latency. It reports the unsigned carry/borrow and the signed overflow, and uses a Start/Busy/Done handshake.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; WIDTH must be divisible by DIGIT.
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  request a new operation; sampled only in IDLE or DONE.
- Sub  in  1  0 = A+B+CarryIn, 1 = A−B; sampled together with Start.
- CarryIn  in  1  carry into bit 0 for addition; ignored when Sub=1.
- A  in  WIDTH  operand A; sampled together with Start.
- B  in  WIDTH  operand B; sampled together with Start.
- Sum  out  WIDTH  result; valid while Done=1 and held until the next accepted Start.
- Carry  out  1  carry out of the MSB (for Sub=1: 1 = no borrow); same validity as Sum.
- Overflow  out  1  signed overflow, i.e. carry into MSB XOR carry out of MSB; same validity as Sum.
- Busy  out  1  high while the operation is running (state RUN).
- Done  out  1  one-cycle pulse: results are valid.

## Operation
- N = WIDTH/DIGIT digit steps. Implementation uses an operand shift register, a result shift register, a carry flop, and a step counter of ceil(log2(N+1)) bits.
- States:
  - IDLE: Busy=0, Done=0.
  - RUN: Busy=1, Done=0.
  - DONE: Busy=0, Done=1.
- Transitions:
  - IDLE→RUN on Start=1.
  - RUN→DONE after N steps.
  - DONE→RUN on Start=1.
  - DONE→IDLE on Start=0.
- On accepting Start:
  - Latch A.
  - Latch B, or ~B when Sub=1.
  - Initialise the carry flop to CarryIn when Sub=0, or to 1 when Sub=1.
  - Clear the step counter.
- Each RUN cycle:
  - Add the low DIGIT bits of both operand registers plus the carry flop.
  - Shift the DIGIT-bit result into the top of the Sum register (LSB digit first, so Sum is in place after N steps).
  - Update the carry flop.
  - Shift both operand registers right by DIGIT.
- Last step: register the carry into the MSB (from inside the final digit slice) and the carry out. Overflow = their XOR.
- Sum is modulo 2^WIDTH. Intermediate Sum contents during RUN are unspecified.
- Start in RUN is ignored: no restart, no queuing.
- Carry and Overflow are updated only at the transition into DONE, and held through IDLE.

## Timing
- Reset values: Sum=0, Carry=0, Overflow=0, Busy=0, Done=0, state IDLE, step counter 0.
- RST=1 at any edge, including mid-RUN, aborts the operation and applies the reset values at that edge. RST has priority over Start.
- Start accepted at edge k. Busy=1 from edge k through edge k+N−1.
  - DIGIT=1, WIDTH=8: 8 edges.
  - DIGIT=WIDTH: 1 edge.
- At edge k+N: Busy=0, Done=1, and Sum/Carry/Overflow are valid.
- At edge k+N+1: Done=0, unless Start was 1 at edge k+N, which starts a new operation back-to-back (Busy=1 again at edge k+N+1).
- Throughput: one result per N+1 cycles with Start held high.
- Operand and Sub changes after the accepting edge have no effect on the running operation.

## Test plan
- **Add with signed overflow.** WIDTH=8, DIGIT=1, A=0x5A, B=0x3C, CarryIn=0, Sub=0 → Done exactly 8 edges after Start; Sum=0x96, Carry=0, Overflow=1.
- **Unsigned wrap and carry-in.**
  - A=0xFF, B=0x01, CarryIn=0 → Sum=0x00, Carry=1, Overflow=0.
  - A=0x00, B=0x00, CarryIn=1 → Sum=0x01, Carry=0.
- **Subtract.**
  - Sub=1, A=0x10, B=0x20 → Sum=0xF0, Carry=0 (borrow), Overflow=0.
  - Sub=1, A=0x80, B=0x01 → Sum=0x7F, Carry=1, Overflow=1.
  - CarryIn toggled during the run has no effect.
- **Handshake.**
  - Start pulsed again at the 3rd RUN cycle is ignored, and the result matches the first operands.
  - Start held high → back-to-back operations with Done pulses every 9 cycles.
  - Done is exactly 1 cycle wide.
- **Reset mid-run.** Assert RST at the 4th RUN edge → all outputs 0 and IDLE on that edge. A following Start with A=0x01, B=0x02 gives Sum=0x03 after 8 edges.
- **Parameter sweep.** DIGIT ∈ {1, 2, 4, 8} with WIDTH=8, plus WIDTH=16 with DIGIT=4; 1000 random operands per configuration checked against a reference model for Sum, Carry and Overflow. Latency equals WIDTH/DIGIT edges in every configuration.
